// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding instruction-memory
// request tracking, and the IF/ID pipeline register with bubble/flush handling.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid,
   output logic [1:0]  o_dbg_state
);

   // Memory handshake: a request is accepted in the cycle where imem_req and
   // imem_ready are both high; exactly one imem_rvalid follows per acceptance.
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HELD  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_addr;
   logic        r_kill;
   logic [31:0] r_hold;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc_plus4;
   logic        r_id_valid;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_fetch_addr_nxt;
   logic        w_kill_nxt;
   logic [31:0] w_hold_nxt;
   logic [31:0] w_id_instr_nxt;
   logic [31:0] w_id_pc_plus4_nxt;
   logic        w_id_valid_nxt;
   logic        w_req;
   logic        w_load;
   logic [31:0] w_load_instr;
   logic        w_redirect;

   // A taken branch only counts when decode is not stalled; otherwise it is re-evaluated.
   assign w_redirect = pc_src && !StallD;

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_fetch_addr_nxt  = r_fetch_addr;
      w_kill_nxt        = r_kill;
      w_hold_nxt        = r_hold;
      w_req             = 1'b0;
      w_load            = 1'b0;
      w_load_instr      = imem_rdata;
      w_id_instr_nxt    = r_id_instr;
      w_id_pc_plus4_nxt = r_id_pc_plus4;
      w_id_valid_nxt    = r_id_valid;

      case (r_state)
         S_FETCH: begin
            w_req = rst_n && !StallF;
            if (w_req && imem_ready) begin
               w_fetch_addr_nxt = r_pc;
               w_pc_nxt         = r_pc + 32'd4;
               w_state_nxt      = S_WAIT;
               w_kill_nxt       = w_redirect;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               w_kill_nxt = 1'b0;
               if (r_kill) begin
                  w_state_nxt = S_FETCH;
               end else if (StallD) begin
                  w_hold_nxt  = imem_rdata;
                  w_state_nxt = S_HELD;
               end else begin
                  w_load      = !w_redirect;
                  w_state_nxt = S_FETCH;
               end
            end else if (w_redirect) begin
               w_kill_nxt = 1'b1;
            end
         end
         S_HELD: begin
            // A redirect here simply drops the buffered word.
            if (!StallD) begin
               w_load       = !w_redirect;
               w_load_instr = r_hold;
               w_state_nxt  = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase

      if (w_redirect) begin
         w_pc_nxt = branch_target;
      end

      if (!StallD) begin
         if (w_load) begin
            w_id_instr_nxt    = w_load_instr;
            w_id_pc_plus4_nxt = r_fetch_addr + 32'd4;
            w_id_valid_nxt    = 1'b1;
         end else begin
            w_id_instr_nxt = NOP_INSTR;
            w_id_valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_fetch_addr  <= 32'd0;
         r_kill        <= 1'b0;
         r_hold        <= 32'd0;
         r_id_instr    <= NOP_INSTR;
         r_id_pc_plus4 <= 32'd0;
         r_id_valid    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_fetch_addr  <= w_fetch_addr_nxt;
         r_kill        <= w_kill_nxt;
         r_hold        <= w_hold_nxt;
         r_id_instr    <= w_id_instr_nxt;
         r_id_pc_plus4 <= w_id_pc_plus4_nxt;
         r_id_valid    <= w_id_valid_nxt;
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign id_instr    = r_id_instr;
   assign id_pc_plus4 = r_id_pc_plus4;
   assign id_valid    = r_id_valid;
   assign o_dbg_state = r_state;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word placed in IF/ID on bubble or flush.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port StallF  input  1  hazard-unit fetch stall; freezes PC, blocks new requests.
REQ-006 Port StallD  input  1  hazard-unit decode stall; freezes IF/ID outputs.
REQ-007 Port pc_src  input  1  branch taken, resolved in ID.
REQ-008 Port branch_target  input  32  redirect address, valid when pc_src=1.
REQ-009 Port imem_req  output  1  instruction-memory request.
REQ-010 Port imem_addr  output  32  request address, word aligned.
REQ-011 Port imem_ready  input  1  same-cycle acceptance of imem_req.
REQ-012 Port imem_rvalid  input  1  read-data valid, one response per accepted request, in order.
REQ-013 Port imem_rdata  input  32  instruction word.
REQ-014 Port id_instr  output  32  IF/ID instruction register.
REQ-015 Port id_pc_plus4  output  32  IF/ID fetch address + 4.
REQ-016 Port id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-017 Register pc holds the next fetch address; fetch_addr holds the outstanding request address.
REQ-018 At most one request outstanding; states FETCH, WAIT, HELD.
REQ-019 FETCH: imem_req=!StallF, imem_addr=pc; on imem_req&&imem_ready -> fetch_addr<=pc, pc<=pc+4 (mod 2^32), go WAIT.
REQ-020 imem_addr may change before acceptance; no stability requirement while imem_ready=0.
REQ-021 WAIT: imem_req=0; on imem_rvalid with kill=0 and StallD=0 -> load IF/ID (id_instr<=imem_rdata, id_pc_plus4<=fetch_addr+4, id_valid<=1), go FETCH.
REQ-022 WAIT: on imem_rvalid with kill=0 and StallD=1 -> capture rdata into hold buffer, go HELD; IF/ID unchanged.
REQ-023 HELD: imem_req=0; when StallD=0 -> load IF/ID from hold buffer, go FETCH.
REQ-024 Any cycle with StallD=0 and no instruction loaded per REQ-021/023 -> IF/ID loads bubble (NOP_INSTR, id_valid=0, id_pc_plus4 unchanged).
REQ-025 StallD=1 -> IF/ID holds all three outputs unchanged.
REQ-026 Redirect: pc_src=1 and StallD=0 -> pc<=branch_target, IF/ID loads bubble (overrides REQ-021/023 load).
REQ-027 Redirect in WAIT, or in FETCH with acceptance same cycle -> kill<=1; next response discarded, kill cleared on that response, state -> FETCH.
REQ-028 Redirect in HELD -> hold buffer discarded, state -> FETCH.
REQ-029 Redirect in FETCH without acceptance -> next-cycle request uses branch_target; no kill.
REQ-030 pc_src=1 with StallD=1 ignored (branch stays in ID, re-evaluated).
REQ-031 StallF=1 with redirect in same cycle: redirect takes priority for pc update.
REQ-032 Fetch latency: response in cycle N with StallD=0 -> id_valid=1 at edge ending cycle N.

Reset
REQ-033 rst_n=0 immediately forces: pc=RESET_PC, state=FETCH, kill=0, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0, hold buffer=0.
REQ-034 imem_req=0 while rst_n=0; first request to RESET_PC in first cycle after release.
REQ-035 Reset mid-transaction: in-flight response after release is not expected by memory (memory shares rst_n); block treats any rvalid in FETCH as ignored.

Verification
REQ-036 Reset release, imem_ready=1, rvalid one cycle later, rdata=32'h2001_0005 -> imem_addr=0, then id_instr=32'h2001_0005, id_pc_plus4=4, id_valid=1.
REQ-037 Back-to-back fetches, zero stalls -> imem_addr 0,4,8; id_pc_plus4 4,8,12; bubbles between (one outstanding).
REQ-038 StallD=1 when rvalid with rdata=32'hAABB_CCDD -> state HELD, IF/ID frozen 3 cycles; StallD=0 -> id_instr=32'hAABB_CCDD.
REQ-039 pc_src=1, branch_target=32'h40 while in WAIT -> response discarded, id_valid=0, next imem_addr=32'h40.
REQ-040 StallF=1 in FETCH for 4 cycles -> imem_req=0, pc unchanged; StallF=0 -> request to same pc.
REQ-041 rst_n pulsed low mid-WAIT -> outputs at reset values asynchronously, first request after release to RESET_PC.
